// File: rtl/template_match_pkg.sv
// Shared types and helpers for the template matching engine.
// Define TM_SQUARED_DIFF_EN to switch the per-pixel cost to the squared difference.
package template_match_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        COMPARE,
        DONE
    } tm_state_t;

    function automatic int cost_width(input int pix_w);
`ifdef TM_SQUARED_DIFF_EN
        return 2 * pix_w;
`else
        return pix_w;
`endif
    endfunction

endpackage

// File: rtl/template_match_engine_store.sv
// Template memory: one write port, combinational read of every class at one address.
module template_store #(
    parameter  int PIX_W       = 8,
    parameter  int NUM_CLASSES = 10,
    parameter  int DEPTH       = 121,
    localparam int CLS_W       = $clog2(NUM_CLASSES),
    localparam int ADDR_W      = $clog2(DEPTH)
) (
    input  logic                              i_clk,
    input  logic                              i_we,
    input  logic [CLS_W-1:0]                  i_class,
    input  logic [ADDR_W-1:0]                 i_waddr,
    input  logic [PIX_W-1:0]                  i_wdata,
    input  logic [ADDR_W-1:0]                 i_raddr,
    output logic [NUM_CLASSES-1:0][PIX_W-1:0] o_rdata
);

    logic [PIX_W-1:0] r_mem [NUM_CLASSES][DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_class][i_waddr] <= i_wdata;
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
            o_rdata[k] = r_mem[k][i_raddr];
        end
    end

endmodule

// File: rtl/template_match_engine.sv
// Streams a frame against all stored templates and reports the closest one.
// Cost metric: absolute difference, or squared difference with TM_SQUARED_DIFF_EN.
module template_match_engine
    import template_match_pkg::*;
#(
    parameter  int PIX_W       = 8,
    parameter  int ROWS        = 11,
    parameter  int COLS        = 11,
    parameter  int NUM_CLASSES = 10,
    localparam int NPIX        = ROWS * COLS,
    localparam int CLS_W       = $clog2(NUM_CLASSES),
    localparam int ADDR_W      = $clog2(NPIX),
    localparam int COST_W      = cost_width(PIX_W),
    localparam int ACC_W       = COST_W + ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PIX_W-1:0]  in_pixel,
    input  logic              tpl_we,
    input  logic [CLS_W-1:0]  tpl_class,
    input  logic [ADDR_W-1:0] tpl_addr,
    input  logic [PIX_W-1:0]  tpl_data,
    output logic              busy,
    output logic              result_valid,
    input  logic              result_ready,
    output logic [CLS_W-1:0]  result_class,
    output logic [ACC_W-1:0]  result_score
);

    tm_state_t r_state, w_next_state;

    logic [ADDR_W-1:0]                 r_pix_idx;
    logic [CLS_W-1:0]                  r_cmp_idx;
    logic [ACC_W-1:0]                  r_acc [NUM_CLASSES];
    logic [CLS_W-1:0]                  r_best_class;
    logic [ACC_W-1:0]                  r_best_score;
    logic [NUM_CLASSES-1:0][PIX_W-1:0] w_tpl_pix;
    logic [NUM_CLASSES-1:0][PIX_W-1:0] w_absdiff;
    logic [NUM_CLASSES-1:0][COST_W-1:0] w_cost;
    logic                              w_accept;
    logic                              w_last_pix;
    logic                              w_last_cmp;
    logic                              w_tpl_we;

    assign w_accept   = in_valid && (r_state == ACCUM);
    assign w_last_pix = (r_pix_idx == ADDR_W'(NPIX - 1));
    assign w_last_cmp = (r_cmp_idx == CLS_W'(NUM_CLASSES - 1));
    assign w_tpl_we   = tpl_we && (r_state == IDLE)
                        && (int'(tpl_class) < NUM_CLASSES) && (int'(tpl_addr) < NPIX);

    template_store #(
        .PIX_W       (PIX_W),
        .NUM_CLASSES (NUM_CLASSES),
        .DEPTH       (NPIX)
    ) u_store (
        .i_clk   (clk),
        .i_we    (w_tpl_we),
        .i_class (tpl_class),
        .i_waddr (tpl_addr),
        .i_wdata (tpl_data),
        .i_raddr (r_pix_idx),
        .o_rdata (w_tpl_pix)
    );

    always_comb begin
        for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
            w_absdiff[k] = (in_pixel >= w_tpl_pix[k]) ? in_pixel - w_tpl_pix[k]
                                                      : w_tpl_pix[k] - in_pixel;
`ifdef TM_SQUARED_DIFF_EN
            w_cost[k] = COST_W'(w_absdiff[k]) * COST_W'(w_absdiff[k]);
`else
            w_cost[k] = w_absdiff[k];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        busy         = 1'b1;
        result_valid = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) w_next_state = ACCUM;
            end
            ACCUM: begin
                in_ready = 1'b1;
                if (w_accept && w_last_pix) w_next_state = COMPARE;
            end
            COMPARE: begin
                if (w_last_cmp) w_next_state = DONE;
            end
            DONE: begin
                result_valid = 1'b1;
                if (result_ready) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned k = 0; k < NUM_CLASSES; k++) r_acc[k] <= '0;
            r_pix_idx    <= '0;
            r_cmp_idx    <= '0;
            r_best_class <= '0;
            r_best_score <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        for (int unsigned k = 0; k < NUM_CLASSES; k++) r_acc[k] <= '0;
                        r_pix_idx <= '0;
                        r_cmp_idx <= '0;
                    end
                end
                ACCUM: begin
                    if (w_accept) begin
                        for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
                            r_acc[k] <= r_acc[k] + ACC_W'(w_cost[k]);
                        end
                        r_pix_idx <= r_pix_idx + 1'b1;
                    end
                end
                COMPARE: begin
                    // Strict less-than keeps the lowest index on ties; class 0 seeds the search.
                    if (r_cmp_idx == '0 || r_acc[r_cmp_idx] < r_best_score) begin
                        r_best_class <= r_cmp_idx;
                        r_best_score <= r_acc[r_cmp_idx];
                    end
                    r_cmp_idx <= r_cmp_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign result_class = r_best_class;
    assign result_score = r_best_score;

endmodule

// File: tb/tb_template_match_engine.sv
// Directed self-checking bench for template_match_engine (both cost-metric builds).
module tb_template_match_engine;
    import template_match_pkg::*;

    localparam int PIX_W  = 8;
    localparam int NC     = 10;
    localparam int NPIX   = 121;
    localparam int CLS_W  = 4;
    localparam int ADDR_W = 7;
    localparam int ACC_W  = cost_width(PIX_W) + ADDR_W;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [PIX_W-1:0]  in_pixel = '0;
    logic              tpl_we = 1'b0;
    logic [CLS_W-1:0]  tpl_class = '0;
    logic [ADDR_W-1:0] tpl_addr = '0;
    logic [PIX_W-1:0]  tpl_data = '0;
    logic              busy;
    logic              result_valid;
    logic              result_ready = 1'b0;
    logic [CLS_W-1:0]  result_class;
    logic [ACC_W-1:0]  result_score;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    template_match_engine #(
        .PIX_W       (PIX_W),
        .ROWS        (11),
        .COLS        (11),
        .NUM_CLASSES (NC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pixel     (in_pixel),
        .tpl_we       (tpl_we),
        .tpl_class    (tpl_class),
        .tpl_addr     (tpl_addr),
        .tpl_data     (tpl_data),
        .busy         (busy),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result_class (result_class),
        .result_score (result_score)
    );

    task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic longint unsigned pix_cost(input int a, input int b);
        longint unsigned d;
        d = (a > b) ? longint'(a - b) : longint'(b - a);
`ifdef TM_SQUARED_DIFF_EN
        return d * d;
`else
        return d;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_tpl(input int c, input int a, input int d);
        tpl_we    = 1'b1;
        tpl_class = CLS_W'(c);
        tpl_addr  = ADDR_W'(a);
        tpl_data  = PIX_W'(d);
        step();
        tpl_we    = 1'b0;
    endtask

    task automatic fill_tpl(input int c, input int d);
        for (int a = 0; a < NPIX; a++) write_tpl(c, a, d);
    endtask

    task automatic begin_frame();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic feed(input string tag, input logic [PIX_W-1:0] v, input bit gaps, input int n);
        int got = 0;
        int guard = 0;
        while (got < n && guard < 1000) begin
            in_valid = gaps ? (guard % 2 == 0) : 1'b1;
            in_pixel = v;
            if (in_valid && in_ready) got++;
            step();
            guard++;
        end
        in_valid = 1'b0;
        check({tag, "_accepted"}, 64'(got), 64'(n));
    endtask

    // Call right after feed(): counts cycles from the last accepting edge.
    task automatic wait_result(input string tag);
        int lat = 1;
        while (!result_valid && lat < 60) begin
            step();
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(NC + 1));
    endtask

    task automatic take_result(input string tag, input int cls, input longint unsigned score);
        check({tag, "_class"}, 64'(result_class), 64'(cls));
        check({tag, "_score"}, 64'(result_score), score);
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
        check({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int changes;
        int not_busy;
        logic [CLS_W-1:0] held_cls;
        logic [ACC_W-1:0] held_score;

        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_valid", 64'(result_valid), 64'd0);
        check("rst_class", 64'(result_class), 64'd0);
        check("rst_score", 64'(result_score), 64'd0);

        for (int k = 0; k < NC; k++) fill_tpl(k, 10 * k);

        begin_frame();
        check("accum_ready", 64'(in_ready), 64'd1);
        feed("exact", 8'd30, 1'b0, NPIX);
        wait_result("exact");
        take_result("exact", 3, 0);

        // 33 sits 3 from template 3 (30) and 7 from template 4 (40).
        begin_frame();
        feed("near", 8'd33, 1'b0, NPIX);
        wait_result("near");
        take_result("near", 3, 121 * pix_cost(33, 30));

        begin_frame();
        feed("bp", 8'd30, 1'b1, NPIX);
        wait_result("bp");
        take_result("bp", 3, 0);

        begin_frame();
        feed("hold", 8'd57, 1'b0, NPIX);
        wait_result("hold");
        held_cls   = result_class;
        held_score = result_score;
        changes    = 0;
        not_busy   = 0;
        for (int i = 0; i < 20; i++) begin
            start = (i == 5);
            step();
            if (!result_valid || result_class !== held_cls || result_score !== held_score) changes++;
            if (!busy) not_busy++;
        end
        start = 1'b0;
        check("hold_stable", 64'(changes), 64'd0);
        check("hold_busy", 64'(not_busy), 64'd0);
        take_result("hold", 6, 121 * pix_cost(57, 60));

        begin_frame();
        feed("abort_part", 8'd90, 1'b0, 60);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_valid", 64'(result_valid), 64'd0);
        begin_frame();
        feed("abort", 8'd30, 1'b0, NPIX);
        wait_result("abort");
        take_result("abort", 3, 0);

        begin_frame();
        feed("midwr_a", 8'd0, 1'b0, 60);
        tpl_we    = 1'b1;
        tpl_class = CLS_W'(0);
        tpl_addr  = ADDR_W'(120);
        tpl_data  = 8'd200;
        step();
        tpl_we    = 1'b0;
        feed("midwr_b", 8'd0, 1'b0, NPIX - 60);
        wait_result("midwr");
        take_result("midwr", 0, 0);

        fill_tpl(5, 20);
        begin_frame();
        feed("tie", 8'd20, 1'b0, NPIX);
        wait_result("tie");
        take_result("tie", 2, 0);

        for (int k = 0; k < NC; k++) fill_tpl(k, 0);
        begin_frame();
        feed("metric", 8'd255, 1'b0, NPIX);
        wait_result("metric");
        take_result("metric", 0, 121 * pix_cost(255, 0));

        // Template write issued in the same cycle as start must be visible to this frame.
        tpl_we    = 1'b1;
        tpl_class = CLS_W'(4);
        tpl_addr  = ADDR_W'(0);
        tpl_data  = 8'd255;
        start     = 1'b1;
        step();
        tpl_we    = 1'b0;
        start     = 1'b0;
        feed("startwr", 8'd255, 1'b0, NPIX);
        wait_result("startwr");
        take_result("startwr", 4, 120 * pix_cost(255, 0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/template_match_engine.md
TEMPLATE_MATCH_ENGINE -- requirements
Module: template_match_engine

Interface
REQ-001 SHALL have parameter PIX_W, default 8, pixel bit width.
REQ-002 SHALL have parameter ROWS, default 11, image rows.
REQ-003 SHALL have parameter COLS, default 11, image columns.
REQ-004 SHALL have parameter NUM_CLASSES, default 10, number of stored templates (digits 0-9).
REQ-005 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have port start  in  1  one-cycle pulse that begins a frame.
REQ-008 SHALL have port in_valid  in  1  pixel valid.
REQ-009 SHALL have port in_ready  out  1  pixel accepted when in_valid && in_ready.
REQ-010 SHALL have port in_pixel  in  PIX_W  pixel, raster order, row 0 col 0 first.
REQ-011 SHALL have port tpl_we  in  1  template write strobe.
REQ-012 SHALL have port tpl_class  in  CLS_W=$clog2(NUM_CLASSES)  template index.
REQ-013 SHALL have port tpl_addr  in  ADDR_W=$clog2(ROWS*COLS)  pixel index, row*COLS+col.
REQ-014 SHALL have port tpl_data  in  PIX_W  template pixel value.
REQ-015 SHALL have port busy  out  1  high whenever state is not IDLE.
REQ-016 SHALL have port result_valid  out  1  result available.
REQ-017 SHALL have port result_ready  in  1  result consumed when result_valid && result_ready.
REQ-018 SHALL have port result_class  out  CLS_W  best-matching template index.
REQ-019 SHALL have port result_score  out  ACC_W  total difference of the best match.

Function
REQ-020 SHALL compute per-pixel cost |in_pixel - tpl[k][idx]| (PIX_W bits) for all NUM_CLASSES templates in parallel.
REQ-021 SHALL accumulate into NUM_CLASSES accumulators of width ACC_W = COST_W + $clog2(ROWS*COLS), making overflow impossible.
REQ-022 SHALL implement FSM IDLE -> ACCUM (on start) -> COMPARE (the cycle after the ROWS*COLS-th pixel is accepted) -> DONE (after NUM_CLASSES compare cycles) -> IDLE (on result handshake).
REQ-023 SHALL clear all accumulators and the pixel index on the start edge taken in IDLE.
REQ-024 SHALL drive in_ready=1 only in ACCUM and accept at most one pixel per cycle; in_valid outside ACCUM is ignored.
REQ-025 SHALL scan one class per COMPARE cycle, index 0 upward; it replaces the best only on a strictly smaller score, so ties resolve to the lowest index.
REQ-026 SHALL assert result_valid in DONE only, holding result_class and result_score stable until result_ready; latency from last pixel accept to result_valid = NUM_CLASSES+1 cycles.
REQ-027 SHALL allow result_ready tied high, with a handshake taking one cycle in DONE.
REQ-028 SHALL ignore start when not in IDLE.
REQ-029 SHALL accept tpl_we only in IDLE; writes in other states are dropped so the templates stay unchanged mid-frame.
REQ-030 SHALL ignore writes with tpl_class >= NUM_CLASSES or tpl_addr >= ROWS*COLS.
REQ-031 SHALL allow start and tpl_we in the same IDLE cycle, with the write committed before the first pixel is used.

Reset
REQ-032 SHALL, on reset, set state=IDLE, in_ready=0, busy=0, result_valid=0, result_class=0, result_score=0, accumulators=0 and pixel index=0.
REQ-033 SHALL leave template storage unaffected by reset.
REQ-034 SHALL let reset mid-frame or in DONE abort the frame and discard any pending result.

Configuration
REQ-035 SHALL, with TM_SQUARED_DIFF_EN defined, use cost (in_pixel - tpl)^2 with COST_W = 2*PIX_W.
REQ-036 SHALL, without TM_SQUARED_DIFF_EN, use the absolute difference with COST_W = PIX_W; the FSM, latency and port list are identical in both builds.

Structure
REQ-037 SHALL place the FSM state enum (IDLE, ACCUM, COMPARE, DONE) and a cost-width helper function in package template_match_pkg.
REQ-038 SHALL implement template storage as sub-module template_store (NUM_CLASSES x ROWS*COLS x PIX_W, one write port, all-class parallel read at one address).

Verification
REQ-039 SHALL verify exact match: all templates hold value 10*k; frame of all 30 -> result_class=3, result_score=0.
REQ-040 SHALL verify tie: templates 2 and 5 identical, frame equal to both -> result_class=2.
REQ-041 SHALL verify backpressure: frame with in_valid toggling every other cycle -> same result as the continuous frame, result_valid exactly NUM_CLASSES+1 cycles after the last accept.
REQ-042 SHALL verify hold: result_ready low for 20 cycles -> result stable, busy=1, start ignored; the handshake then returns to IDLE.
REQ-043 SHALL verify reset abort: reset after 60 pixels, then a new full frame -> result reflects only the new frame.
REQ-044 SHALL verify metric: template 0 all 0, frame all 255 -> result_score = 121*255 without the macro and 121*65025 with it.
